// File: rtl/spi_ram_ctrl.sv
// Command-decoding RAM behind the SPI slave: address/data write and read commands
// on an internal memory, with read bytes held on dout/tx_valid for the slave's serialiser.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int TX_HOLD   = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       err,
    output logic       busy
);

    localparam int CNT_W = $clog2(TX_HOLD + 1);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SEND
    } tx_state_t;

    logic [1:0]           cmd;
    logic [7:0]           payload;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_armed;
    logic                 rd_armed;
    logic                 wr_en;
    logic                 rd_go;
    logic                 cmd_rej;
    logic [CNT_W-1:0]     cnt;
    logic [7:0]           mem [MEM_DEPTH];
    tx_state_t            state;
    tx_state_t            state_nxt;

    assign cmd     = din[9:8];
    assign payload = din[7:0];
    assign busy    = (state != TX_IDLE);

    always_comb begin
        wr_en   = 1'b0;
        rd_go   = 1'b0;
        cmd_rej = 1'b0;
        if (rx_valid) begin
            case (cmd)
                CMD_WR_DATA: begin
                    if (wr_armed) wr_en = 1'b1;
                    else          cmd_rej = 1'b1;
                end
                CMD_RD_DATA: begin
                    if (rd_armed && state == TX_IDLE) rd_go = 1'b1;
                    else                              cmd_rej = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A fresh RD_ADDR takes priority over the post-load increment so it always targets the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            wr_armed <= 1'b0;
            rd_armed <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= cmd_rej;
            if (rx_valid && cmd == CMD_WR_ADDR) begin
                wr_addr  <= payload[ADDR_SIZE-1:0];
                wr_armed <= 1'b1;
            end else if (wr_en) begin
                wr_addr <= wr_addr + ADDR_SIZE'(1);
            end
            if (rx_valid && cmd == CMD_RD_ADDR) begin
                rd_addr  <= payload[ADDR_SIZE-1:0];
                rd_armed <= 1'b1;
            end else if (state == TX_LOAD) begin
                rd_addr <= rd_addr + ADDR_SIZE'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= payload;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= TX_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE: if (rd_go) state_nxt = TX_LOAD;
            TX_LOAD: state_nxt = TX_SEND;
            TX_SEND: if (cnt == '0) state_nxt = TX_IDLE;
            default: state_nxt = TX_IDLE;
        endcase
    end

    // Memory is sampled one edge after the accepted read, so a write on the previous edge is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            tx_valid <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                TX_LOAD: begin
                    dout     <= mem[rd_addr];
                    tx_valid <= 1'b1;
                    cnt      <= CNT_W'(TX_HOLD - 1);
                end
                TX_SEND: begin
                    if (cnt == '0) tx_valid <= 1'b0;
                    else           cnt      <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: command vector tables plus hand-built sequences for
// back-to-back hazards, busy rejection and mid-read reset; read data scored via a queue.
module tb_spi_ram_ctrl;

    localparam logic [1:0] WA = 2'b00;
    localparam logic [1:0] WD = 2'b01;
    localparam logic [1:0] RA = 2'b10;
    localparam logic [1:0] RD = 2'b11;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] pl;
        int         exp_err;
        bit         rd;
        logic [7:0] exp_dout;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       err;
    logic       busy;

    int         checks  = 0;
    int         errors  = 0;
    int         err_cnt = 0;
    logic [7:0] exp_q[$];
    vec_t       vt[22];

    logic       prev_tv  = 1'b0;
    logic       prev_err = 1'b0;
    int         hold_len = 0;
    logic [7:0] held     = 8'h00;

    spi_ram_ctrl #(
        .MEM_DEPTH(256),
        .ADDR_SIZE(8),
        .TX_HOLD(9)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .din(din),
        .rx_valid(rx_valid),
        .dout(dout),
        .tx_valid(tx_valid),
        .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: scores read bytes, hold length, dout stability and err pulse width.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_tv  = 1'b0;
            prev_err = 1'b0;
            hold_len = 0;
        end else begin
            if (err) begin
                err_cnt++;
                check("err_one_cycle", prev_err, 0);
            end
            if (tx_valid && !prev_tv) begin
                if (exp_q.size() == 0) check("unexpected_read", tx_valid, 0);
                else                   check("rd_dout", dout, exp_q.pop_front());
                held     = dout;
                hold_len = 1;
            end else if (tx_valid) begin
                hold_len++;
                check("dout_stable", dout, held);
            end else if (prev_tv) begin
                check("tx_hold_len", hold_len, 9);
                check("dout_after_fall", dout, held);
            end
            prev_tv  = tx_valid;
            prev_err = err;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] p);
        din      = {c, p};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        din      = '0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int e0;
        e0 = err_cnt;
        if (v.rd) exp_q.push_back(v.exp_dout);
        send(v.cmd, v.pl);
        if (v.rd) begin
            idle(12);
            check({tag, "_read_done"}, exp_q.size(), 0);
            exp_q.delete();
        end else begin
            idle(1);
            check({tag, "_busy"}, busy, 0);
        end
        check({tag, "_err"}, err_cnt - e0, v.exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int e0;

        vt[0]  = '{WA, 8'h10, 0, 1'b0, 8'h00};
        vt[1]  = '{WD, 8'hA5, 0, 1'b0, 8'h00};
        vt[2]  = '{RA, 8'h10, 0, 1'b0, 8'h00};
        vt[3]  = '{RD, 8'h00, 0, 1'b1, 8'hA5};
        vt[4]  = '{WA, 8'hFE, 0, 1'b0, 8'h00};
        vt[5]  = '{WD, 8'h11, 0, 1'b0, 8'h00};
        vt[6]  = '{WD, 8'h22, 0, 1'b0, 8'h00};
        vt[7]  = '{WD, 8'h33, 0, 1'b0, 8'h00};
        vt[8]  = '{WD, 8'h44, 0, 1'b0, 8'h00};
        vt[9]  = '{RA, 8'hFE, 0, 1'b0, 8'h00};
        vt[10] = '{RD, 8'h00, 0, 1'b1, 8'h11};
        vt[11] = '{RD, 8'h00, 0, 1'b1, 8'h22};
        vt[12] = '{RD, 8'h00, 0, 1'b1, 8'h33};
        vt[13] = '{RD, 8'h5A, 0, 1'b1, 8'h44};
        vt[14] = '{WA, 8'h40, 0, 1'b0, 8'h00};
        vt[15] = '{WD, 8'h3C, 0, 1'b0, 8'h00};
        // After a mid-read reset: both arm flags cleared, memory retained.
        vt[16] = '{RD, 8'h00, 1, 1'b0, 8'h00};
        vt[17] = '{WD, 8'h55, 1, 1'b0, 8'h00};
        vt[18] = '{RA, 8'h00, 0, 1'b0, 8'h00};
        vt[19] = '{RD, 8'h00, 0, 1'b1, 8'h33};
        vt[20] = '{RA, 8'h40, 0, 1'b0, 8'h00};
        vt[21] = '{RD, 8'h00, 0, 1'b1, 8'h3C};

        rst_n    = 1'b1;
        din      = '0;
        rx_valid = 1'b0;
        #1 rst_n = 1'b0;
        idle(2);
        check("rst_dout", dout, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);

        for (int i = 0; i < 16; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Back-to-back write then read of the same address.
        e0 = err_cnt;
        exp_q.push_back(8'h7E);
        send(WA, 8'h20);
        send(WD, 8'h7E);
        send(RA, 8'h20);
        send(RD, 8'h00);
        idle(12);
        check("b2b_read_done", exp_q.size(), 0);
        check("b2b_err", err_cnt - e0, 0);

        // WR_DATA on edge N, RD_DATA on edge N+1.
        e0 = err_cnt;
        exp_q.push_back(8'h9C);
        send(RA, 8'h30);
        send(WA, 8'h30);
        send(WD, 8'h9C);
        send(RD, 8'h00);
        idle(12);
        check("raw_read_done", exp_q.size(), 0);
        check("raw_err", err_cnt - e0, 0);

        // Read while busy is rejected; write to the displayed address and RD_ADDR are accepted.
        e0 = err_cnt;
        exp_q.push_back(8'hA5);
        send(RA, 8'h10);
        send(RD, 8'h00);
        idle(3);
        check("busy_mid_read", busy, 1);
        send(RD, 8'h00);
        send(WA, 8'h10);
        send(WD, 8'h66);
        send(RA, 8'h20);
        idle(6);
        check("busy_read_done", exp_q.size(), 0);
        check("busy_err", err_cnt - e0, 1);
        check("busy_cleared", busy, 0);
        e0 = err_cnt;
        exp_q.push_back(8'h7E);
        send(RD, 8'h00);
        idle(12);
        check("rearm_while_busy_read", exp_q.size(), 0);
        check("rearm_while_busy_err", err_cnt - e0, 0);

        // Reset asserted during TX_SEND.
        exp_q.push_back(8'h3C);
        send(RA, 8'h40);
        send(RD, 8'h00);
        idle(4);
        check("pre_rst_tx_valid", tx_valid, 1);
        check("pre_rst_dout", dout, 8'h3C);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx_valid", tx_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_dout", dout, 0);
        check("async_rst_queue", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        for (int i = 16; i < 22; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Command-decoding RAM block that sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit received word (2-bit command plus 8-bit payload, qualified by rx_valid).
- Executes address-load, write and read operations on an internal synchronous memory.
- Returns read bytes to the slave on dout/tx_valid, which the slave shifts out on MISO.
- Holds dout/tx_valid stable long enough for the slave's 8-bit serialiser.

Parameters:
MEM_DEPTH, 256, number of 8-bit words; must equal 2**ADDR_SIZE.
ADDR_SIZE, 8, address width; 1..8; address is taken from payload[ADDR_SIZE-1:0].
TX_HOLD, 9, cycles tx_valid stays high per read (>= 9 covers the slave's load state plus 8 bit states).

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
din  input  10  command word from SPI slave: din[9:8]=cmd, din[7:0]=payload
rx_valid  input  1  din qualifier, sampled each rising clk
dout  output  8  read data to SPI slave
tx_valid  output  1  dout qualifier, held TX_HOLD cycles per read
err  output  1  one-cycle pulse on a rejected command
busy  output  1  high while the read path is in TX_LOAD or TX_SEND

Behaviour:
Interface:
- Reset rst_n is asynchronous, active-low; clock is clk.

Reset:
- dout=0, tx_valid=0, err=0, busy=0.
- wr_addr=0, rd_addr=0, wr_armed=0, rd_armed=0, tx FSM=TX_IDLE, hold counter=0.
- Memory array has no reset; contents are retained across rst_n.
- Reset asserted mid-read drops tx_valid and busy asynchronously. The pending read is discarded.

Command decode (only when rx_valid=1 at a rising edge; cmd=din[9:8]):
- 00 WR_ADDR: wr_addr<=payload[ADDR_SIZE-1:0]; wr_armed<=1.
- 01 WR_DATA:
  - If wr_armed: mem[wr_addr]<=payload; wr_addr<=wr_addr+1, wrapping MEM_DEPTH-1 -> 0.
  - Else: no write, and err pulses.
- 10 RD_ADDR: rd_addr<=payload[ADDR_SIZE-1:0]; rd_armed<=1. Accepted even while busy; it affects only the next read.
- 11 RD_DATA (payload ignored):
  - Accepted only if rd_armed=1 and the FSM is in TX_IDLE.
  - Otherwise err pulses and the command is dropped. A read while busy is dropped with err.
- Armed flags stay set after data accesses, so bursts auto-increment without reloading the address.
- err is registered: it is high for exactly one cycle, the cycle after the offending edge.
- rx_valid=0: no state change in the decode path.

Read FSM:
- TX_IDLE -> TX_LOAD on an accepted RD_DATA at edge N.
- TX_LOAD (edge N+1):
  - dout<=mem[rd_addr]; tx_valid<=1.
  - rd_addr<=rd_addr+1, wrapping.
  - counter<=TX_HOLD-1.
  - Go to TX_SEND.
- TX_SEND: counter decrements each cycle. When it reaches 0, tx_valid<=0 at the next edge and the FSM returns to TX_IDLE.
- Timing: tx_valid is high for exactly TX_HOLD cycles, starting on edge N+1. dout is stable throughout and holds its last value after tx_valid falls.
- busy=1 in TX_LOAD and TX_SEND.

Hazards:
- WR_DATA to address X at edge N, then RD_DATA of X at edge N+1: dout returns the new data (the memory write completes before the TX_LOAD read).
- A write accepted while in TX_SEND to the address currently on dout does not change dout.

Widths:
- Addresses are ADDR_SIZE bits with modulo-MEM_DEPTH increment.
- Payload bits above ADDR_SIZE are ignored for address commands.

Test Plan:
1. Reset, then WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> tx_valid rises one cycle after the RD_DATA edge with dout=0xA5, stays high 9 cycles, err never pulses.
2. Burst: WR_ADDR 0xFE, WR_DATA 0x11, 0x22, 0x33; then RD_ADDR 0xFE and three RD_DATA commands, each sent after tx_valid falls -> reads return 0x11, 0x22, 0x33 (addresses 0xFE, 0xFF, 0x00 wrap); rd_addr ends at 0x01.
3. After reset: WR_DATA 0x55 before any WR_ADDR -> err pulses 1 cycle, no write. RD_DATA before RD_ADDR -> err pulses, tx_valid stays 0.
4. RD_DATA issued 3 cycles after a previous read's tx_valid rose -> err pulses. The first read's dout/tx_valid are unaffected and still last 9 cycles total.
5. rst_n low for 1 cycle during TX_SEND -> tx_valid, busy and dout go to 0 immediately. After release, RD_DATA gives err (rd_armed cleared). Re-arming with RD_ADDR of the earlier address returns the previously written value (memory retained).
6. WR_ADDR 0x20, WR_DATA 0x7E, then RD_ADDR 0x20, RD_DATA on back-to-back cycles -> dout=0x7E.
